// File: rtl/edge_detect_multi.sv
// edge_detect_multi: N-channel synchronise / debounce / edge-pulse block with
// per-channel sticky flags and saturating event counters for CSR readout.
//
// Each channel works like this:
//   1. A shift-chain synchroniser brings the raw input into the clock domain.
//   2. A debounce filter accepts a new level once it has held for DEB_CYCLES
//      consecutive cycles.
//   3. An accepted transition whose direction is enabled by mode registers a
//      one-cycle pulse on the same edge that updates level.
//   4. The sticky flag and the event counter are driven from the registered
//      pulse, so they update one cycle after it. This lets a clear that is
//      asserted while pulse is high collide with the set or increment, and
//      the set or increment wins.
module edge_detect_multi #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8,
  parameter bit RST_LVL     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         sig,
  input  logic [1:0]           mode,
  input  logic [N-1:0]         sticky_clr,
  input  logic                 cnt_clr,
  output logic [N-1:0]         pulse,
  output logic [N-1:0]         level,
  output logic [N-1:0]         sticky,
  output logic [N*CNT_W-1:0]   cnt,
  output logic [N-1:0]         cnt_sat
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          dcnt_q;
    logic                   level_q;
    logic                   pulse_q;
    logic                   sticky_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   s;
    logic                   accept;
    logic                   qual;
    logic                   sat;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != level_q) && (dcnt_q == DEB_LAST);
    // A rising edge is qualified by mode[0] and a falling edge by mode[1].
    assign qual   = accept && ((s && mode[0]) || (!s && mode[1]));
    assign sat    = &cnt_q;

    // Synchroniser shift chain; the last stage feeds the filter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= {SYNC_STAGES{RST_LVL}};
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], sig[i]};
    end

    // Debounce: count consecutive disagreeing cycles, accept on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dcnt_q  <= '0;
        level_q <= RST_LVL;
      end else if (s == level_q) begin
        dcnt_q  <= '0;
      end else if (accept) begin
        dcnt_q  <= '0;
        level_q <= s;
      end else begin
        dcnt_q  <= dcnt_q + 1'b1;
      end
    end

    // Registered qualified-edge pulse, raised on the edge that updates level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pulse_q <= 1'b0;
      else        pulse_q <= qual;
    end

    // Sticky flag: set by the pulse, write-1-to-clear; set wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             sticky_q <= 1'b0;
      else if (pulse_q)       sticky_q <= 1'b1;
      else if (sticky_clr[i]) sticky_q <= 1'b0;
    end

    // Saturating event counter; a clear that meets an event leaves a count of one.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt_q <= '0;
      else if (cnt_clr)          cnt_q <= pulse_q ? CNT_W'(1) : '0;
      else if (pulse_q && !sat)  cnt_q <= cnt_q + 1'b1;
    end

    assign pulse[i]                 = pulse_q;
    assign level[i]                 = level_q;
    assign sticky[i]                = sticky_q;
    assign cnt[i*CNT_W +: CNT_W]    = cnt_q;
    assign cnt_sat[i]               = sat;
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi. It drives a default-width instance and
// a 2-bit-counter instance from the same stimulus, so that counter saturation
// can be exercised. Inputs change 1 ns after a posedge, and outputs are sampled
// at that same point.
module tb_edge_detect_multi;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   sig;
  logic [1:0]     mode;
  logic [N-1:0]   sticky_clr;
  logic           cnt_clr;

  logic [N-1:0]   pulse, level, sticky, cnt_sat;
  logic [N*8-1:0] cnt;
  logic [N-1:0]   pulse_w2, level_w2, sticky_w2, cnt_sat_w2;
  logic [N*2-1:0] cnt_w2;

  int checks   = 0;
  int failures = 0;

  edge_detect_multi #(.N(N), .SYNC_STAGES(2), .DEB_CYCLES(4), .CNT_W(8), .RST_LVL(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sig(sig), .mode(mode), .sticky_clr(sticky_clr),
    .cnt_clr(cnt_clr), .pulse(pulse), .level(level), .sticky(sticky), .cnt(cnt),
    .cnt_sat(cnt_sat));

  edge_detect_multi #(.N(N), .SYNC_STAGES(2), .DEB_CYCLES(4), .CNT_W(2), .RST_LVL(1'b0)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .sig(sig), .mode(mode), .sticky_clr(sticky_clr),
    .cnt_clr(cnt_clr), .pulse(pulse_w2), .level(level_w2), .sticky(sticky_w2), .cnt(cnt_w2),
    .cnt_sat(cnt_sat_w2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs n cycles and returns the number of cycles in which pulse[ch] was high.
  task automatic run_count(input int n, input int ch, output int npulse);
    npulse = 0;
    for (int k = 0; k < n; k++) begin
      step(1);
      if (pulse[ch]) npulse++;
    end
  endtask

  // Runs n cycles and returns the OR of pulse over those cycles.
  task automatic run_or(input int n, output logic [N-1:0] seen);
    seen = '0;
    for (int k = 0; k < n; k++) begin
      step(1);
      seen |= pulse;
    end
  endtask

  task automatic clear_all();
    sticky_clr = '1;
    cnt_clr    = 1'b1;
    step(1);
    sticky_clr = '0;
    cnt_clr    = 1'b0;
  endtask

  int           np;
  logic [N-1:0] seen;

  initial begin
    rst_n = 1'b0; sig = '0; mode = 2'b01; sticky_clr = '0; cnt_clr = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("reset_pulse", 32'(pulse), 32'h0);
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_cnt",   cnt,        32'h0);

    // A rising edge on channel 0 produces a pulse 6 posedges after the input changes.
    sig[0] = 1'b1;
    step(5);
    chk("rise_pulse_early", 32'(pulse[0]), 32'h0);
    step(1);
    chk("rise_pulse",       32'(pulse[0]), 32'h1);
    chk("rise_level",       32'(level[0]), 32'h1);
    step(1);
    chk("rise_pulse_width", 32'(pulse[0]), 32'h0);
    chk("rise_sticky",      32'(sticky[0]), 32'h1);
    chk("rise_cnt0",        32'(cnt[7:0]), 32'h1);
    sig[0] = 1'b0;
    run_or(12, seen);
    chk("fall_no_pulse_m01", 32'(seen), 32'h0);
    chk("fall_level",        32'(level[0]), 32'h0);

    // Reset asserted mid-run, with no clock edge, clears the outputs immediately.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_sticky", 32'(sticky), 32'h0);
    chk("async_rst_cnt",    cnt,         32'h0);
    chk("async_rst_level",  32'(level),  32'h0);
    step(1);
    rst_n = 1'b1;
    run_or(20, seen);
    chk("post_rst_no_pulse", 32'(seen), 32'h0);

    // With mode=00 the filter keeps running but no pulse is produced.
    mode = 2'b00;
    sig[0] = 1'b1;
    run_or(10, seen);
    chk("mode00_no_pulse", 32'(seen), 32'h0);
    chk("mode00_level",    32'(level[0]), 32'h1);
    sig[0] = 1'b0;
    step(10);

    // Both-edges mode on channel 2: a 3-cycle glitch is rejected, then a 10-cycle low pulse is reported.
    mode = 2'b11;
    sig[2] = 1'b1;
    step(10);
    clear_all();
    sig[2] = 1'b0;
    step(3);
    sig[2] = 1'b1;
    run_count(10, 2, np);
    chk("glitch_no_pulse", np, 0);
    chk("glitch_level",    32'(level[2]), 32'h1);
    sig[2] = 1'b0;
    run_count(10, 2, np);
    chk("fall_pulse_cnt",  np, 1);
    chk("fall_level2",     32'(level[2]), 32'h0);
    sig[2] = 1'b1;
    run_count(10, 2, np);
    chk("rise_pulse_cnt",  np, 1);
    chk("cnt2_two",        32'(cnt[23:16]), 32'h2);

    // Counter saturation on channel 1 of the 2-bit instance.
    mode = 2'b01;
    clear_all();
    for (int e = 1; e <= 5; e++) begin
      sig[1] = 1'b1;
      step(10);
      chk("w2_cnt1",     32'(cnt_w2[3:2]), (e < 3) ? e : 3);
      chk("w2_cnt_sat1", 32'(cnt_sat_w2[1]), (e >= 3) ? 1 : 0);
      sig[1] = 1'b0;
      step(10);
    end
    chk("w8_cnt1_five", 32'(cnt[15:8]), 32'h5);
    sig[1] = 1'b1;
    step(6);
    chk("sixth_pulse", 32'(pulse[1]), 32'h1);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("w2_clr_coinc", 32'(cnt_w2[3:2]), 32'h1);
    chk("w8_clr_coinc", 32'(cnt[15:8]),   32'h1);
    chk("w2_sat_clear", 32'(cnt_sat_w2[1]), 32'h0);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_alone", 32'(cnt[15:8]), 32'h0);
    sig[1] = 1'b0;
    step(10);

    // A sticky clear asserted while the pulse is high loses to the set.
    clear_all();
    sig[3] = 1'b1;
    step(6);
    chk("ch3_pulse", 32'(pulse[3]), 32'h1);
    sticky_clr[3] = 1'b1;
    step(1);
    chk("sticky_set_wins", 32'(sticky[3]), 32'h1);
    step(1);
    sticky_clr[3] = 1'b0;
    chk("sticky_cleared", 32'(sticky[3]), 32'h0);

    // Inputs held high across reset release are reported once, on every channel together.
    rst_n = 1'b0;
    sig = '1;
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("rel_pulse_early", 32'(pulse), 32'h0);
    step(1);
    chk("rel_pulse_all",   32'(pulse), 32'hF);
    step(1);
    chk("rel_pulse_once",  32'(pulse), 32'h0);
    run_or(10, seen);
    chk("rel_no_repeat",   32'(seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
